// File: rtl/apb_cmd_master.sv
// Turns a valid/ready command stream into single APB3 transfers and returns data/error on a response channel.
// Optional ACCESS watchdog enabled by `define APB_CMD_MASTER_TIMEOUT_EN; one transfer outstanding at a time.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic   timeout;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] acc_cnt;

  // Counts completed ACCESS cycles; timeout fires during the last allowed one.
  assign timeout = (acc_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
    end else if (state == SETUP) begin
      acc_cnt <= '0;
    end else if (state == ACCESS && !pready && !timeout) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            pwrite    <= cmd_write;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // Normal completion takes priority over a watchdog abort on the same cycle.
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timeout) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: drives commands, models the APB slave, checks responses and cycle timing.
module tb_apb_cmd_master;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr, busy;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] rd, input logic se, input int nwait, input int nbp);
    rsp_t e;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    prdata = rd; pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b0;
    exp_q.push_back('{rdata: (wr ? '0 : rd), err: se});
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_busy", busy, 1);
    @(negedge clk);
    for (int i = 0; i <= nwait; i++) begin
      pready  = (i == nwait);
      pslverr = (i == nwait) ? se : ~se;
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, a);
      chk("access_pwdata", pwdata, wd);
      chk("access_pwrite", pwrite, wr);
      chk("access_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    pready = 1'b0; pslverr = 1'b0;
    for (int j = 0; j < nbp; j++) begin
      cmd_valid = 1'b1;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_err", rsp_err, se);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_psel", psel, 0);
      @(negedge clk);
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_psel_low", psel, 0);
    rsp_ready = 1'b1;
    chk("sb_depth", exp_q.size(), 1);
    e = exp_q.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", rsp_err, e.err);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_psel", psel, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int bad;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    xfer(1'b1, 8'h00, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0, 0, 0);
    xfer(1'b0, 8'h04, 32'h0BAD_F00D, 32'h1234_5678, 1'b0, 0, 0);
    xfer(1'b1, 8'h08, 32'hCAFE_0001, 32'h0, 1'b0, 3, 0);
    xfer(1'b0, 8'h0C, 32'h0, 32'hA5A5_5A5A, 1'b1, 0, 5);
    xfer(1'b0, 8'hFC, 32'h0, 32'h8000_0001, 1'b0, 1, 2);
    chk("paddr_kept", paddr, 8'hFC);

    // Asynchronous reset while in ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'h1111_2222; pready = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_penable", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_psel", psel, 0);
    chk("arst_penable", penable, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    chk("arst_cmd_ready", cmd_ready, 1);
    xfer(1'b1, 8'h14, 32'h3333_4444, 32'h0, 1'b0, 0, 0);

    // Slave never answers.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_wdata = '0;
    prdata = 32'hFFFF_FFFF; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    acc = 0;
    for (int k = 0; k < 40 && !rsp_valid; k++) begin
      if (penable) acc++;
      @(negedge clk);
    end
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_access_cycles", acc, TO);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", psel, 0);
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    chk("to_cmd_ready", cmd_ready, 1);
`else
    bad = 0;
    for (int k = 0; k < 110; k++) begin
      if (!busy || rsp_valid || !penable) bad++;
      @(negedge clk);
    end
    chk("hang_cycles_bad", bad, 0);
    rst_n = 1'b0;
    #1 chk("hang_arst_psel", psel, 0);
    @(negedge clk); rst_n = 1'b1;
`endif
    @(negedge clk);
    xfer(1'b0, 8'h24, 32'h0, 32'h7654_3210, 1'b0, 0, 0);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Upstream APB master stage that turns a simple valid/ready command stream (from a host link or debug port) into single APB3 transfers driving the generated register-file slave. It has one outstanding transfer at a time. It returns read data and error status on a valid/ready response channel. An optional watchdog aborts transfers whose slave never asserts `pready`.

## Interface
- `ADDR_WIDTH`, 8, APB address width.
- `DATA_WIDTH`, 32, APB data width.
- `TIMEOUT_CYCLES`, 16, number of ACCESS cycles allowed before abort (only used with the watchdog). Must be ≥1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_write`  in  1  1=write, 0=read.
- `cmd_addr`  in  ADDR_WIDTH  target byte address.
- `cmd_wdata`  in  DATA_WIDTH  write data (ignored for reads).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and aborted transfers.
- `rsp_err`  out  1  slave error or timeout.
- `paddr`  out  ADDR_WIDTH  APB address.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `pwdata`  out  DATA_WIDTH  APB write data.
- `prdata`  in  DATA_WIDTH  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB slave error.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- All outputs are driven from registers.
- Reset values:
  - State is IDLE.
  - `cmd_ready`=1.
  - `psel`=`penable`=`pwrite`=`rsp_valid`=`rsp_err`=`busy`=0.
  - `paddr`, `pwdata` and `rsp_rdata` are all zero.
- **IDLE:** `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: latch `cmd_addr`/`cmd_wdata`/`cmd_write` into `paddr`/`pwdata`/`pwrite`.
  - Then go to SETUP, with `cmd_ready`=0.
- **SETUP** (exactly 1 cycle): `psel`=1, `penable`=0. Next state is ACCESS.
- **ACCESS:** `psel`=1, `penable`=1. The state holds while `pready`=0.
  - `paddr`, `pwdata` and `pwrite` stay stable throughout.
  - On `pready`=1:
    - `rsp_rdata` takes `prdata` for a read, or 0 for a write.
    - `rsp_err` takes `pslverr`.
    - `psel` and `penable` go to 0.
    - Go to RESP.
- **RESP:** `rsp_valid`=1, and the response fields are held stable until `rsp_ready`=1.
  - On handshake: `rsp_valid`=0, then go to IDLE (`cmd_ready`=1 next cycle).
- `paddr`, `pwdata` and `pwrite` keep their last values outside a transfer. They change only on command acceptance.
- `cmd_valid` arriving while not in IDLE is not accepted; the upstream holds it.
- A new command is never accepted in the same cycle a response handshake completes.
- `pslverr` is sampled only in ACCESS with `pready`=1; it is ignored at other times.
- An asynchronous reset in any state returns to IDLE at once:
  - `psel`/`penable` drop immediately.
  - Any pending response is discarded and `rsp_valid`=0.

## Timing
- Command accepted at edge 0. Then `psel`=1 in cycle 1 (SETUP), and `penable`=1 in cycle 2 (ACCESS).
- With zero-wait `pready`, `rsp_valid`=1 in cycle 3.
- If `rsp_ready`=1 in cycle 3, `cmd_ready`=1 in cycle 4. The minimum is 4 cycles per transfer.
- Each wait state (`pready`=0 in ACCESS) adds 1 cycle.
- Each cycle of `rsp_ready`=0 in RESP adds 1 cycle.

## Configuration
- Macro `APB_CMD_MASTER_TIMEOUT_EN`.
- **Defined:** an ACCESS-cycle counter of width clog2(TIMEOUT_CYCLES+1) is cleared on entering ACCESS.
  - If `pready`=0 at the end of the TIMEOUT_CYCLES-th ACCESS cycle, the transfer is aborted: `psel`/`penable`→0, `rsp_err`=1, `rsp_rdata`=0, go to RESP.
  - `pready`=1 on that same cycle completes normally, so the normal completion wins.
- **Undefined:** no counter. ACCESS waits indefinitely, and `rsp_err` reflects `pslverr` only.

## Test plan
- **Zero-wait write:** write `0x0000_0005` to `0x00` with `pready`=1.
  - `psel` in cycle 1, `penable` in cycle 2.
  - `rsp_valid` in cycle 3 with `rsp_err`=0, `rsp_rdata`=0.
  - `pwdata`=`0x0000_0005` while `psel` is high.
- **Read:** read `0x04` while the slave drives `prdata`=`0x1234_5678`.
  - `rsp_rdata`=`0x1234_5678`, `rsp_err`=0.
  - `pwrite`=0 throughout.
- **Wait states:** `pready`=0 for 3 ACCESS cycles, then 1.
  - `rsp_valid` in cycle 6.
  - `paddr`/`pwdata`/`pwrite` stable for all 4 ACCESS cycles.
- **Slave error and backpressure:** `pslverr`=1 with `pready`=1, and `rsp_ready`=0 for 5 cycles.
  - `rsp_err`=1 and `rsp_valid` held for 6 cycles.
  - `cmd_ready`=0 and `psel`=0 during the hold.
  - A second `cmd_valid` is not accepted until after the handshake.
- **Timeout:** with the macro defined, `TIMEOUT_CYCLES`=16 and `pready` held at 0.
  - Abort after 16 ACCESS cycles, with `rsp_err`=1 and `rsp_rdata`=0.
  - Without the macro, `busy` stays 1 and `rsp_valid` stays 0 for more than 100 cycles.
- **Reset mid-transfer:** assert `rst_n`=0 in ACCESS.
  - `psel`/`penable`/`rsp_valid`=0 asynchronously.
  - After release, `cmd_ready`=1, and the next write completes normally.
